// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator slice.
// Ports: none (package only).
// Holds default widths and the accumulator state encoding.
package mac_pkg;

  localparam int DATA_W = 16;  // operand width; 2*DATA_W feeds the 32-bit adder
  localparam int ACC_W  = 32;  // accumulator / adder width
  localparam int CNT_W  = 8;   // term counter width (saturating)

  // IDLE: no partial sum held. ACCUM: partial sum of the current group held.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/kogge_stone_32bit.sv
// Purpose: 32-bit parallel-prefix (Kogge-Stone) adder, s = a + b + cin.
// Latency: purely combinational. Backpressure: n/a.
// Ports: a, b (32b addends), cin (carry in), s (32b sum), cout (carry out).
module kogge_stone_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [31:0] p_bit;
  logic [31:0] g [0:5];
  logic [31:0] p [0:4];

  assign p_bit = a ^ b;
  // cin is folded into bit 0's generate so the prefix tree needs no extra column.
  assign g[0]  = (a & b) | {31'b0, p_bit[0] & cin};
  assign p[0]  = p_bit;

  // Each level doubles the span: shifting in zeros means spans that already
  // reach bit 0 simply keep their final generate.
  for (genvar l = 0; l < 5; l++) begin : g_level
    localparam int D = 1 << l;
    assign g[l+1] = g[l] | (p[l] & (g[l] << D));
    if (l < 4) begin : g_prop
      assign p[l+1] = p[l] & (p[l] << D);
    end
  end

  assign s    = p_bit ^ {g[5][30:0], cin};
  assign cout = g[5][31];

endmodule

// File: rtl/mac_accumulator_32bit.sv
// Purpose: pipelined unsigned multiply-accumulate; one 32-bit sum per 'last'-terminated group.
// Latency: pair presented/accepted in cycle c -> out_valid visible in cycle c+2; 1 pair/clk.
// Backpressure: out_valid & ~out_ready freezes S1, S2 and accumulator; in_ready drops.
// Ports: clk, rst (sync, active-high); a, b, in_last, in_valid / in_ready (operand side);
//        clear (drop partial group); result, ovf, count, out_valid / out_ready (result side).
module mac_accumulator_32bit
  import mac_pkg::*;
#(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int CNT_W  = mac_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  result,
  output logic              ovf,
  output logic [CNT_W-1:0]  count,
  output logic              out_valid,
  input  logic              out_ready
);

  logic             adv;
  logic             accept;
  logic             s2_fire;
  logic [ACC_W-1:0] prod;

  // Stage 1: registered product
  logic [ACC_W-1:0] p;
  logic             p_last;
  logic             p_vld;

  // Stage 2: running group state
  logic [ACC_W-1:0] acc;
  logic             ovf_acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  state_t           state;
  state_t           state_nxt;

  logic [ACC_W-1:0] sum_s;
  logic             sum_cout;

  // The pipeline only moves when the output slot is empty or being drained.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = ~rst & ~clear & adv;
  assign accept   = in_valid & in_ready;
  // clear wins over any S2 update in the same cycle.
  assign s2_fire  = adv & p_vld & ~clear;

  assign prod    = ACC_W'(a) * ACC_W'(b);
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  kogge_stone_32bit u_add (
    .a    (acc),
    .b    (p),
    .cin  (1'b0),
    .s    (sum_s),
    .cout (sum_cout)
  );

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      p_vld <= 1'b0;
    end else if (adv) begin
      p      <= prod;
      p_last <= in_last;
      p_vld  <= accept;
    end
  end

  // Group state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (s2_fire) begin
      state_nxt = p_last ? IDLE : ACCUM;
    end
  end

  // Stage 2: accumulate, or close the group into the output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      ovf       <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (clear) begin
        acc     <= '0;
        ovf_acc <= 1'b0;
        cnt     <= '0;
      end else if (s2_fire) begin
        if (p_last) begin
          result  <= sum_s;
          ovf     <= ovf_acc | sum_cout;
          count   <= cnt_inc;
          acc     <= '0;
          ovf_acc <= 1'b0;
          cnt     <= '0;
        end else begin
          acc     <= sum_s;
          ovf_acc <= ovf_acc | sum_cout;
          cnt     <= cnt_inc;
        end
      end

      // A result taken this cycle may be replaced by a new one in the same cycle.
      if (s2_fire && p_last) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
